// File: rtl/sequence_generator_if.sv
// Bus between a pattern source and the serial sequence generator.
// The master side loads a pattern and controls the run; the slave side
// (the generator) returns the serial bit stream and its status.
interface sequence_generator_if #(
  parameter int MAXLEN = 44
);
  logic              load;
  logic [MAXLEN-1:0] pattern;
  logic [5:0]        length;
  logic              rep;
  logic              hold;
  logic              stop;
  logic              X;
  logic              x_valid;
  logic              busy;
  logic              done;
  logic [5:0]        idx;

  modport master (
    output load, pattern, length, rep, hold, stop,
    input  X, x_valid, busy, done, idx
  );

  modport slave (
    input  load, pattern, length, rep, hold, stop,
    output X, x_valid, busy, done, idx
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern generator: captures a pattern of up to MAXLEN bits and shifts
// it out MSB-first (from bit length-1) one bit per clock. It can repeat the
// pattern with no gap, freeze on hold, and abort on stop.
module sequence_generator #(
  parameter int MAXLEN = 44
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_generator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam logic [5:0] MAX_LEN6 = 6'(MAXLEN);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] sh_q, sh_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        last_q, last_d;   // captured length-1, reload point for repeat
  logic              rep_q, rep_d;
  logic [5:0]        len_clamp;

  // Oversized lengths are clamped to the shift register width
  always_comb begin
    len_clamp = (bus.length > MAX_LEN6) ? MAX_LEN6 : bus.length;
  end

  // State and data registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state and data-path update
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        // A zero-length request is dropped; load is only honoured here
        if (bus.load && (bus.length != 6'd0)) begin
          sh_d    = bus.pattern;
          idx_d   = len_clamp - 6'd1;
          last_d  = len_clamp - 6'd1;
          rep_d   = bus.rep;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.stop) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (idx_q != 6'd0) begin
            idx_d = idx_q - 6'd1;
          end else if (rep_q) begin
            idx_d = last_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Single pulse cycle; stop lands in IDLE as well
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.X       = 1'b0;
    bus.x_valid = 1'b0;
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.idx     = idx_q;
    if (state_q == SEND) begin
      bus.X       = sh_q[idx_q];
      bus.x_valid = 1'b1;
    end
  end

endmodule
